// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
//   Round-robin arbiter that shares the UART TX FIFO write port between two
//   frame requesters (0: command responses, 1: status/error reports). A granted
//   frame is latched whole and then written into the FIFO one byte per cycle,
//   least-significant byte first, stalling while FIFO_FULL is high. Frames are
//   atomic: the other requester waits until the current frame is finished.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   REQx, LENx, DATAx frame request (held until ACKx), length in bytes, payload
//   ACKx              one-cycle pulse, frame latched (first SEND cycle)
//   DONEx             one-cycle pulse, last byte of the frame written
//   FIFO_FULL         TX FIFO full, already in the CLK domain
//   FIFO_WR_DATA/INC  FIFO write byte and strobe (data forced to 0 when idle)
//   BUSY              high while a frame is being sent
module tx_frame_arbiter #(
  parameter int MAX_BYTES = 4,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ0,
  input  logic                   REQ1,
  input  logic [LW-1:0]          LEN0,
  input  logic [LW-1:0]          LEN1,
  input  logic [8*MAX_BYTES-1:0] DATA0,
  input  logic [8*MAX_BYTES-1:0] DATA1,
  output logic                   ACK0,
  output logic                   ACK1,
  output logic                   DONE0,
  output logic                   DONE1,
  input  logic                   FIFO_FULL,
  output logic [7:0]             FIFO_WR_DATA,
  output logic                   FIFO_WR_INC,
  output logic                   BUSY
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);

  state_t                   state;
  logic                     owner;
  logic                     rr_ptr;
  logic [8*MAX_BYTES-1:0]   frame_buf;
  logic [LW-1:0]            len;
  logic [LW-1:0]            idx;
  logic                     grant;
  logic                     wr_inc;
  logic                     last_byte;
  logic [7:0]               cur_byte;

  // Oversized lengths are sent as a full MAX_BYTES frame.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  // Winner when granting: rr_ptr breaks ties, otherwise the lone requester.
  assign grant = (REQ0 && REQ1) ? rr_ptr : REQ1;

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx == LW'(k)) cur_byte = frame_buf[8*k +: 8];
    end
  end

  assign wr_inc       = (state == SEND) && !FIFO_FULL && (idx < len);
  assign last_byte    = (idx == len - LW'(1));
  assign FIFO_WR_INC  = wr_inc;
  assign FIFO_WR_DATA = wr_inc ? cur_byte : 8'h00;
  assign BUSY         = (state == SEND);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      frame_buf <= '0;
      len       <= '0;
      idx       <= '0;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
    end else begin
      ACK0  <= 1'b0;
      ACK1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            owner     <= grant;
            rr_ptr    <= ~grant;
            frame_buf <= grant ? DATA1 : DATA0;
            len       <= clamp_len(grant ? LEN1 : LEN0);
            idx       <= '0;
            state     <= SEND;
            ACK0      <= ~grant;
            ACK1      <= grant;
          end
        end
        SEND: begin
          // A zero-length frame spends exactly one cycle in SEND.
          if (len == '0) begin
            state <= IDLE;
            DONE0 <= ~owner;
            DONE1 <= owner;
          end else if (wr_inc) begin
            idx <= idx + LW'(1);
            if (last_byte) begin
              state <= IDLE;
              DONE0 <= ~owner;
              DONE1 <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
module tb_tx_frame_arbiter;

  localparam int MB = 4;
  localparam int LW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1;
  logic [LW-1:0] LEN0, LEN1;
  logic [31:0]   DATA0, DATA1;
  logic          ACK0, ACK1, DONE0, DONE1;
  logic          FIFO_FULL;
  logic [7:0]    FIFO_WR_DATA;
  logic          FIFO_WR_INC;
  logic          BUSY;

  tx_frame_arbiter #(.MAX_BYTES(MB), .LW(LW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .LEN0(LEN0), .LEN1(LEN1),
    .DATA0(DATA0), .DATA1(DATA1),
    .ACK0(ACK0), .ACK1(ACK1),
    .DONE0(DONE0), .DONE1(DONE1),
    .FIFO_FULL(FIFO_FULL),
    .FIFO_WR_DATA(FIFO_WR_DATA),
    .FIFO_WR_INC(FIFO_WR_INC),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // {ACK0, ACK1, DONE0, DONE1, BUSY, FIFO_WR_INC}
  function automatic logic [5:0] outs();
    return {ACK0, ACK1, DONE0, DONE1, BUSY, FIFO_WR_INC};
  endfunction

  task automatic do_reset();
    RST = 1'b1; REQ0 = 0; REQ1 = 0; LEN0 = 0; LEN1 = 0;
    DATA0 = 0; DATA1 = 0; FIFO_FULL = 0;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic          rst, r0, r1;
    logic [LW-1:0] l0, l1;
    logic [31:0]   d0, d1;
    logic          full;
    logic [5:0]    e_out;
    logic [7:0]    e_data;
  } vec_t;

  vec_t tbl[13];

  task automatic run_table();
    tbl[0]  = '{0, 1, 0, 3'd2, 3'd0, 32'hDEAD12AB, 32'h0, 0, 6'b000000, 8'h00};
    tbl[1]  = '{0, 0, 0, 3'd2, 3'd0, 32'hDEAD12AB, 32'h0, 0, 6'b100011, 8'hAB};
    tbl[2]  = '{0, 0, 0, 3'd2, 3'd0, 32'hDEAD12AB, 32'h0, 0, 6'b000011, 8'h12};
    tbl[3]  = '{0, 0, 0, 3'd2, 3'd0, 32'hDEAD12AB, 32'h0, 0, 6'b001000, 8'h00};
    tbl[4]  = '{1, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 0, 6'b000000, 8'h00};
    tbl[5]  = '{0, 1, 1, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b000000, 8'h00};
    tbl[6]  = '{0, 1, 1, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b100011, 8'hA0};
    tbl[7]  = '{0, 1, 1, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b001000, 8'h00};
    tbl[8]  = '{0, 1, 1, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b010011, 8'hB1};
    tbl[9]  = '{0, 1, 1, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b000100, 8'h00};
    tbl[10] = '{0, 1, 1, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b100011, 8'hA0};
    tbl[11] = '{0, 0, 0, 3'd1, 3'd1, 32'h55AA33A0, 32'h66BB44B1, 0, 6'b001000, 8'h00};
    tbl[12] = '{0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 0, 6'b000000, 8'h00};
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      RST = tbl[i].rst; REQ0 = tbl[i].r0; REQ1 = tbl[i].r1;
      LEN0 = tbl[i].l0; LEN1 = tbl[i].l1;
      DATA0 = tbl[i].d0; DATA1 = tbl[i].d1; FIFO_FULL = tbl[i].full;
      @(negedge CLK);
      chk($sformatf("tbl%0d_ctrl", i), 32'(outs()), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_data", i), 32'(FIFO_WR_DATA), 32'(tbl[i].e_data));
    end
  endtask

  // ---------------- hand-written corner sequences ----------------
  task automatic seq_backpressure();
    logic [7:0] wq[$];
    int full_wr, done_cnt, done_cyc, last_wr;
    full_wr = 0; done_cnt = 0; done_cyc = -1; last_wr = -1;
    next_cycle();
    REQ1 = 1; LEN1 = 3'd4; DATA1 = 32'h44332211;
    for (int c = 1; c < 16; c++) begin
      next_cycle();
      REQ1 = 0;
      FIFO_FULL = (c >= 2 && c <= 4);
      @(negedge CLK);
      if (FIFO_WR_INC) begin
        wq.push_back(FIFO_WR_DATA);
        last_wr = c;
        if (FIFO_FULL) full_wr++;
      end
      if (DONE1) begin done_cnt++; done_cyc = c; end
    end
    FIFO_FULL = 0;
    chk("bp_count", 32'(wq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_byte%0d", k), (k < wq.size()) ? 32'(wq[k]) : 32'hFFFF, 32'h11 * (k + 1));
    chk("bp_wr_while_full", 32'(full_wr), 32'd0);
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);
    chk("bp_done_cycle", 32'(done_cyc), 32'(last_wr + 1));
  endtask

  task automatic seq_len_edges();
    logic [31:0] got;
    int wr_cnt, done_cnt;
    next_cycle();
    REQ0 = 1; LEN0 = 3'd0; DATA0 = 32'h11223344;
    next_cycle();
    REQ0 = 0;
    @(negedge CLK);
    chk("len0_ack", 32'(outs()), 32'(6'b100010));
    next_cycle();
    @(negedge CLK);
    chk("len0_done", 32'(outs()), 32'(6'b001000));

    got = 0; wr_cnt = 0; done_cnt = 0;
    next_cycle();
    REQ0 = 1; LEN0 = 3'd7; DATA0 = 32'hD4C3B2A1;
    for (int c = 1; c < 9; c++) begin
      next_cycle();
      REQ0 = 0;
      @(negedge CLK);
      if (FIFO_WR_INC) begin
        if (wr_cnt < 4) got[8*wr_cnt +: 8] = FIFO_WR_DATA;
        wr_cnt++;
      end
      if (DONE0) done_cnt++;
    end
    chk("len7_count", 32'(wr_cnt), 32'd4);
    chk("len7_bytes", got, 32'hD4C3B2A1);
    chk("len7_done_cnt", 32'(done_cnt), 32'd1);
  endtask

  task automatic seq_reset_mid_frame();
    next_cycle();
    REQ0 = 1; REQ1 = 0; LEN0 = 3'd4; DATA0 = 32'hDDCCBBAA;
    next_cycle();
    REQ0 = 0;
    next_cycle();
    @(negedge CLK);
    chk("rst_pre_byte2", {23'd0, FIFO_WR_INC, FIFO_WR_DATA}, {23'd0, 1'b1, 8'hBB});
    next_cycle();
    chk("rst_pre_byte3", {23'd0, FIFO_WR_INC, FIFO_WR_DATA}, {23'd0, 1'b1, 8'hCC});
    RST = 1;
    #1;
    chk("rst_async_outs", {18'd0, outs(), FIFO_WR_DATA}, 32'd0);
    next_cycle();
    REQ0 = 1; REQ1 = 1; LEN0 = 3'd1; LEN1 = 3'd1;
    DATA0 = 32'h000000E0; DATA1 = 32'h000000F1;
    next_cycle();
    RST = 0;
    @(negedge CLK);
    chk("rst_no_done", 32'(outs()), 32'd0);
    next_cycle();
    REQ0 = 0; REQ1 = 0;
    @(negedge CLK);
    chk("rst_grant0", 32'(outs()), 32'(6'b100011));
    chk("rst_grant0_data", 32'(FIFO_WR_DATA), 32'hE0);
    next_cycle();
    @(negedge CLK);
    chk("rst_done0", 32'(outs()), 32'(6'b001000));
  endtask

  // ---------------- randomized run against a frame-queue model ----------------
  logic       m_busy, m_owner, m_prio;
  logic [1:0] m_ack, m_done;
  logic [7:0] m_q[$];

  task automatic run_random(input int ncyc);
    logic       p_req[2];
    logic [2:0] p_len[2];
    logic [31:0] p_dat[2];
    logic       e_inc, w, cur_req;
    logic [7:0] e_data;
    logic [1:0] na, nd, acks_now;
    int         n;
    do_reset();
    m_busy = 0; m_owner = 0; m_prio = 0; m_ack = 0; m_done = 0; m_q.delete();
    for (int i = 0; i < 2; i++) begin p_req[i] = 0; p_len[i] = 0; p_dat[i] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      next_cycle();
      REQ0 = p_req[0]; LEN0 = p_len[0]; DATA0 = p_dat[0];
      REQ1 = p_req[1]; LEN1 = p_len[1]; DATA1 = p_dat[1];
      FIFO_FULL = ($urandom_range(0, 9) < 3);
      @(negedge CLK);
      e_inc  = m_busy && !FIFO_FULL && (m_q.size() > 0);
      e_data = e_inc ? m_q[0] : 8'h00;
      chk("rnd_ctrl", 32'(outs()), 32'({m_ack[0], m_ack[1], m_done[0], m_done[1], m_busy, e_inc}));
      chk("rnd_data", 32'(FIFO_WR_DATA), 32'(e_data));
      acks_now = m_ack;
      na = '0; nd = '0;
      if (!m_busy) begin
        if (REQ0 || REQ1) begin
          w = (REQ0 && REQ1) ? m_prio : REQ1;
          n = w ? int'(LEN1) : int'(LEN0);
          if (n > MB) n = MB;
          for (int k = 0; k < n; k++) m_q.push_back(w ? DATA1[8*k +: 8] : DATA0[8*k +: 8]);
          m_owner = w; m_prio = !w; m_busy = 1; na[w] = 1'b1;
        end
      end else if (m_q.size() == 0) begin
        m_busy = 0; nd[m_owner] = 1'b1;
      end else if (e_inc) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin m_busy = 0; nd[m_owner] = 1'b1; end
      end
      m_ack = na; m_done = nd;
      for (int i = 0; i < 2; i++) begin
        cur_req = (i == 0) ? REQ0 : REQ1;
        if (cur_req && acks_now[i]) begin
          if ($urandom_range(0, 1) == 0) p_req[i] = 0;
          else begin p_len[i] = 3'($urandom_range(0, 7)); p_dat[i] = $urandom; end
        end else if (!cur_req && $urandom_range(0, 2) == 0) begin
          p_req[i] = 1; p_len[i] = 3'($urandom_range(0, 7)); p_dat[i] = $urandom;
        end
      end
    end
    REQ0 = 0; REQ1 = 0; FIFO_FULL = 0;
  endtask

  initial begin
    do_reset();
    @(negedge CLK);
    chk("reset_outs", {18'd0, outs(), FIFO_WR_DATA}, 32'd0);
    run_table();
    seq_backpressure();
    seq_len_edges();
    seq_reset_mid_frame();
    run_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Round-robin arbiter sharing the single write port of the UART TX FIFO between two frame requesters: requester 0 carries command responses (RF read data, ALU results) and requester 1 carries status/error reports. Each request is a frame of up to MAX_BYTES bytes presented in parallel. The block serialises the frame into the FIFO one byte per cycle, least-significant byte first, honouring FIFO_FULL. Frames are atomic: bytes from different requesters never interleave in the FIFO.

## Interface
- MAX_BYTES, 4, maximum frame length in bytes (≥1).
- LW, $clog2(MAX_BYTES+1), width of length fields (3 for default).
- CLK  in  1  system clock; single clock domain.
- RST  in  1  asynchronous, active-high reset.
- REQ0, REQ1  in  1  frame request, held until ACKx.
- LEN0, LEN1  in  LW  frame length in bytes; valid with REQx.
- DATA0, DATA1  in  8*MAX_BYTES  frame payload; byte k = DATA[8k+7:8k]; valid with REQx.
- ACK0, ACK1  out  1  one-cycle pulse: frame latched; requester may drop REQ and change DATA/LEN.
- DONE0, DONE1  out  1  one-cycle pulse: last byte of that requester's frame written to FIFO.
- FIFO_FULL  in  1  TX FIFO full (already synchronised to CLK).
- FIFO_WR_DATA  out  8  byte to FIFO.
- FIFO_WR_INC  out  1  FIFO write strobe; one byte per high cycle.
- BUSY  out  1  high while a frame is being sent (state SEND).

## Operation
- States: IDLE, SEND. Registers: state, owner (1 bit), rr_ptr (1 bit, priority requester), frame buffer (8*MAX_BYTES), len (LW), idx (LW).
- IDLE: at the clock edge, if any REQx is high, grant per priority. If both are high, rr_ptr wins. If only one is high, that one wins. At that edge: latch DATA/LEN of the winner, set owner, set rr_ptr to the other requester, set idx=0, enter SEND, and register ACK(owner)=1 for the next cycle.
- LEN clamp: LEN > MAX_BYTES is treated as MAX_BYTES. LEN = 0 produces no FIFO writes: SEND lasts one cycle, then returns to IDLE with DONE(owner).
- SEND: FIFO_WR_INC = !FIFO_FULL && (idx < len) (combinational from registers and FIFO_FULL). FIFO_WR_DATA = buffer byte[idx]; it is 0 when FIFO_WR_INC=0.
  - On each edge with FIFO_WR_INC=1, idx increments.
  - When the written byte is byte len-1, or len=0, go to IDLE and register DONE(owner)=1 for the next cycle.
- FIFO_FULL during SEND stalls the frame: no write, idx holds, data holds. Stall length is unbounded. The other requester waits.
- REQx is sampled only in IDLE. A requester that keeps REQ high after ACK is treated as a new frame.
- Reset (any time, including mid-frame): state=IDLE, rr_ptr=0, owner=0, idx=0, len=0, buffer=0; ACKx, DONEx, BUSY, FIFO_WR_INC, FIFO_WR_DATA all 0. Bytes already written stay in the FIFO. The remainder of the frame is dropped and no DONE is issued.

## Timing
- REQ sampled at edge t0. ACK is high and the first FIFO_WR_INC can occur in cycle t0→t1 (if not full).
- Throughput is 1 byte/cycle while not full. An n-byte unstalled frame occupies SEND for n cycles.
- DONE is high in the first IDLE cycle after the last write. The same edge that ends that IDLE cycle may grant the next frame. Minimum gap between frames is therefore 1 idle cycle.
- ACK is high during the first SEND cycle. DONE is high during the first IDLE cycle. ACK and DONE of the same frame never overlap; they coincide only in count for LEN=0 (ACK in SEND, DONE the cycle after).
- ACK0/ACK1 are mutually exclusive, and so are DONE0/DONE1.

## Test plan
- Single frame: REQ0, LEN0=2, DATA0=0x…_12AB, FIFO never full.
  - Required: ACK0 in cycle 1; writes 0xAB then 0x12 in cycles 1–2; DONE0 in cycle 3; BUSY high for cycles 1–2.
- Contention and fairness: after reset, REQ0 and REQ1 held continuously, each with LEN=1.
  - Required: grant order 0,1,0,1…; FIFO sequence alternates DATA0[7:0], DATA1[7:0]; no interleaving within frames.
- Backpressure: LEN1=4, DATA1=0x44332211, FIFO_FULL high for 3 cycles after the first byte.
  - Required: FIFO receives exactly 0x11,0x22,0x33,0x44; no FIFO_WR_INC while full; DONE1 one cycle after the 0x44 write.
- Length edges: LEN0=0 gives ACK0 then DONE0 with zero writes. LEN0=7 gives exactly 4 writes (clamped).
- Reset mid-frame: assert RST after 2 of 4 bytes are written.
  - Required: all outputs 0 immediately (asynchronously); no DONE.
  - Next request after release is granted to requester 0 when both are pending (rr_ptr=0).
